// File: rtl/key_tone_synth_if.sv
// key_tone_synth_if
//   Bundles the key_code stream and the voice outputs of key_tone_synth.
//   master : the producer side (song player / keyboard path / bench).
//            It drives key_code and observes the voice outputs.
//   slave  : the synth side. It consumes key_code and drives the voice outputs.
//   Signals:
//     key_code  [7:0]  scan code stream, 8'hF0 = release
//     note_on          gate
//     note_idx  [3:0]  last accepted note 1..8, 0 = none since reset
//     env_level [7:0]  envelope amplitude
//     audio_out [15:0] signed sample to the codec serialiser
interface key_tone_synth_if;
  logic [7:0]        key_code;
  logic              note_on;
  logic [3:0]        note_idx;
  logic [7:0]        env_level;
  logic signed [15:0] audio_out;

  modport master (
    output key_code,
    input  note_on,
    input  note_idx,
    input  env_level,
    input  audio_out
  );

  modport slave (
    input  key_code,
    output note_on,
    output note_idx,
    output env_level,
    output audio_out
  );
endinterface

// File: rtl/key_tone_synth.sv
// key_tone_synth
//   Monophonic key-driven tone voice. The key_code stream is debounced by a
//   run-length filter. Accepted note codes open the gate and select a DDS
//   phase increment, and the release code 8'hF0 closes the gate. A square
//   wave taken from the phase MSB is scaled by a linear attack/release
//   envelope.
//   Ports:
//     clock    system clock, all state on posedge
//     reset_n  asynchronous active-low reset
//     bus      key_tone_synth_if.slave (key_code in; note_on, note_idx,
//              env_level, audio_out out, all registered)
module key_tone_synth #(
  parameter int         STABLE_CYC = 4,
  parameter int         ENV_DIV    = 50000,
  parameter logic [7:0] ATK_STEP   = 8'd16,
  parameter logic [7:0] REL_STEP   = 8'd4
) (
  input  logic            clock,
  input  logic            reset_n,
  key_tone_synth_if.slave bus
);

  // The counter tracks how many consecutive samples matched the previous one.
  // A run of STABLE_CYC identical samples therefore holds STABLE_CYC-1 matches.
  localparam int CNT_W = $clog2(STABLE_CYC);
  localparam int DIV_W = $clog2(ENV_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ENV_DIV - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ATTACK  = 2'd1;
  localparam logic [1:0] ST_SUSTAIN = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [7:0] CODE_REL = 8'hF0;

  // Map a scan code to {valid, note index, 24-bit phase increment}.
  function automatic logic [28:0] decode_note(input logic [7:0] code);
    logic [28:0] r;
    case (code)
      8'h2B:   r = {1'b1, 4'd1, 24'd88};
      8'h34:   r = {1'b1, 4'd2, 24'd99};
      8'h33:   r = {1'b1, 4'd3, 24'd111};
      8'h3B:   r = {1'b1, 4'd4, 24'd117};
      8'h42:   r = {1'b1, 4'd5, 24'd132};
      8'h4B:   r = {1'b1, 4'd6, 24'd148};
      8'h4C:   r = {1'b1, 4'd7, 24'd166};
      8'h52:   r = {1'b1, 4'd8, 24'd176};
      default: r = {1'b0, 4'd0, 24'd0};
    endcase
    return r;
  endfunction

  logic [7:0]       code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       state_q, state_d;
  logic [7:0]       env_q, env_d;
  logic             note_on_q, note_on_d;
  logic [3:0]       idx_q, idx_d;
  logic [23:0]      inc_q, inc_d;
  logic [23:0]      phase_q, phase_d;
  logic [15:0]      audio_q, audio_d;

  logic        accept_s;
  logic [28:0] dec_s;
  logic        note_evt_s;
  logic        rel_evt_s;
  logic        tick_s;
  logic [8:0]  atk_sum_s;
  logic [15:0] mag_s;

  // Run-length filter: one acceptance strobe per stable run of key_code.
  always_comb begin
    code_d = bus.key_code;
    if (bus.key_code != code_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    accept_s   = (cnt_d == CNT_LAST) && (cnt_q != CNT_LAST);
    dec_s      = decode_note(bus.key_code);
    note_evt_s = accept_s && dec_s[28];
    rel_evt_s  = accept_s && (bus.key_code == CODE_REL) &&
                 ((state_q == ST_ATTACK) || (state_q == ST_SUSTAIN));
  end

  // Voice control: gate events, envelope steps, DDS accumulation and output sample.
  always_comb begin
    state_d   = state_q;
    env_d     = env_q;
    note_on_d = note_on_q;
    idx_d     = idx_q;
    inc_d     = inc_q;

    tick_s = (div_q == DIV_LAST);
    if (tick_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    // The accumulator advances with the increment in force before this edge.
    if (state_q != ST_IDLE) begin
      phase_d = phase_q + inc_q;
    end else begin
      phase_d = phase_q;
    end

    atk_sum_s = {1'b0, env_q} + {1'b0, ATK_STEP};

    // An event on a tick edge consumes that tick.
    if (note_evt_s) begin
      idx_d     = dec_s[27:24];
      inc_d     = dec_s[23:0];
      note_on_d = 1'b1;
      state_d   = ST_ATTACK;
    end else if (rel_evt_s) begin
      note_on_d = 1'b0;
      state_d   = ST_RELEASE;
    end else if (tick_s) begin
      case (state_q)
        ST_ATTACK: begin
          if (atk_sum_s >= 9'd255) begin
            env_d   = 8'd255;
            state_d = ST_SUSTAIN;
          end else begin
            env_d = atk_sum_s[7:0];
          end
        end
        ST_SUSTAIN: begin
          env_d = 8'd255;
        end
        ST_RELEASE: begin
          if (env_q <= REL_STEP) begin
            env_d   = 8'd0;
            state_d = ST_IDLE;
          end else begin
            env_d = env_q - REL_STEP;
          end
        end
        default: begin
          env_d = env_q;
        end
      endcase
    end else begin
      env_d = env_q;
    end

    mag_s = {1'b0, env_q, 7'b0};
    if (phase_q[23]) begin
      audio_d = 16'd0 - mag_s;
    end else begin
      audio_d = mag_s;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      code_q    <= 8'd0;
      cnt_q     <= '0;
      div_q     <= '0;
      state_q   <= ST_IDLE;
      env_q     <= 8'd0;
      note_on_q <= 1'b0;
      idx_q     <= 4'd0;
      inc_q     <= 24'd0;
      phase_q   <= 24'd0;
      audio_q   <= 16'd0;
    end else begin
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      state_q   <= state_d;
      env_q     <= env_d;
      note_on_q <= note_on_d;
      idx_q     <= idx_d;
      inc_q     <= inc_d;
      phase_q   <= phase_d;
      audio_q   <= audio_d;
    end
  end

  assign bus.note_on   = note_on_q;
  assign bus.note_idx  = idx_q;
  assign bus.env_level = env_q;
  assign bus.audio_out = audio_q;

endmodule
